uart_rx_core: RTL and testbench

- Synthesizable 8N1 UART receiver for the user project; it deserializes the line driven by the bench UART transmitter on mprj_io[5].
- Oversamples the incoming serial line using a runtime bit-period divisor and validates the start and stop bits.
- Buffers received bytes in a small first-word-fall-through FIFO.
- Hands bytes to the user-project bus logic through a valid/ready interface, with sticky-free error pulses for framing and overrun.

---
 rtl/uart_rx_core_if.sv | 22 ++
 rtl/uart_rx_core.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// Receive byte stream handshake between uart_rx_core and its consumer.
//   rx_data  : byte at the receive FIFO head
//   rx_valid : FIFO not empty
//   rx_ready : consumer takes the head byte on a clock where rx_valid && rx_ready
// master modport belongs to the receiver, slave modport to the consumer.
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a first-word-fall-through receive FIFO.
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   rx_en      : receiver enable; dropping it abandons any frame in progress
//   clk_div    : clocks per bit, values below 4 behave as 4
//   ser_rx     : asynchronous serial line, idle high
//   rx_bus     : valid/ready byte stream out of the FIFO head
//   rx_count   : FIFO occupancy
//   frame_err  : one-cycle pulse when a stop bit reads 0
//   overrun    : one-cycle pulse when a good byte is dropped on a full FIFO
//   rx_busy    : receiver is inside a frame (FSM not idle)
//
// state     | meaning
// S_IDLE    | line idle, waiting for a falling edge on the synchronized line
// S_START   | counting to mid start bit to reject glitches
// S_DATA    | sampling 8 data bits at mid bit, LSB first
// S_STOP    | sampling the stop bit, push or flag framing error
// S_WAIT_HIGH | after a framing error, wait for the line to return high
module uart_rx_core #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_en,
    input  logic [DIV_W-1:0]              clk_div,
    input  logic                          ser_rx,
    uart_rx_core_if.master                rx_bus,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          rx_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic             sync1;
    logic             rx_s;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             push_req;
    logic             frame_d;

    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] half_m1;
    logic [DIV_W-1:0] full_m1;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             drop;

    // Divisor is captured at frame start so a mid-frame change cannot skew sampling.
    assign div_eff = (clk_div < DIV_W'(4)) ? DIV_W'(4) : clk_div;
    assign half_m1 = (div_q >> 1) - DIV_W'(1);
    assign full_m1 = div_q - DIV_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_W'(4);
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            sync1   <= ser_rx;
            rx_s    <= sync1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        push_req = 1'b0;
        frame_d  = 1'b0;

        if (!rx_en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        cnt_d   = '0;
                        div_d   = div_eff;
                    end
                end
                S_START: begin
                    if (cnt_q == half_m1) begin
                        cnt_d = '0;
                        idx_d = '0;
                        // A line already back high at mid start bit was a glitch.
                        state_d = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == full_m1) begin
                        cnt_d   = '0;
                        shreg_d = {rx_s, shreg_q[7:1]};
                        if (idx_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == full_m1) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            push_req = 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            frame_d = 1'b1;
                            state_d = S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign rx_busy = (state_q != S_IDLE);

    assign fifo_full = (rx_count == FULL_CNT);
    assign pop       = rx_bus.rx_valid && rx_bus.rx_ready;
    // A same-cycle pop frees the slot, so a push on a full FIFO still lands.
    assign push_ok   = push_req && (!fifo_full || pop);
    assign drop      = push_req && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rx_count  <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= shreg_q;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   rx_count <= rx_count + CNT_W'(1);
                2'b01:   rx_count <= rx_count - CNT_W'(1);
                default: rx_count <= rx_count;
            endcase
            frame_err <= frame_d;
            overrun   <= drop;
        end
    end

    assign rx_bus.rx_valid = (rx_count != '0);
    assign rx_bus.rx_data  = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

    localparam int DEPTH = 4;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_en = 1'b0;
    logic [DIV_W-1:0] clk_div = 16'd347;
    logic             ser_rx = 1'b1;
    logic [2:0]       rx_count;
    logic             frame_err;
    logic             overrun;
    logic             rx_busy;

    uart_rx_core_if bus ();

    uart_rx_core #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_en     (rx_en),
        .clk_div   (clk_div),
        .ser_rx    (ser_rx),
        .rx_bus    (bus),
        .rx_count  (rx_count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fe_seen = 0;
    int ov_seen = 0;

    // Reference model: expected FIFO contents and expected pulse totals.
    logic [7:0] exp_q[$];
    int exp_fe = 0;
    int exp_ov = 0;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_seen++;
        if (overrun === 1'b1) ov_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int eff_div(input int cd);
        return (cd < 4) ? 4 : cd;
    endfunction

    // A frame with a good stop bit enters the FIFO if there is room, else is an overrun.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok) exp_fe++;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ov++;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives start, 8 data bits LSB first, then the stop bit; the line is left at the stop value.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int per);
        ser_rx = 1'b0;
        wait_clk(per);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            wait_clk(per);
        end
        ser_rx = stop;
        wait_clk(per);
    endtask

    task automatic pop_one(output logic [7:0] d);
        d = bus.rx_data;
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx_en = 1'b0;
        ser_rx = 1'b1;
        bus.rx_ready = 1'b0;
        wait_clk(3);
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.rx_valid); end
        checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", rx_count); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.rx_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        rst_n = 1'b1;
        exp_q.delete();
        wait_clk(2);
    endtask

    task automatic test_single;
        logic [7:0] d;
        clk_div = 16'd347;
        rx_en = 1'b1;
        wait_clk(2);
        send_byte(8'h3D, 1'b1, 347);
        model_frame(8'h3D, 1'b1);
        wait_clk(8);
        checks++; if (rx_count !== 3'(exp_q.size())) begin errors++; $display("FAIL single_count: got %0d expected %0d", rx_count, exp_q.size()); end
        checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.rx_valid); end
        checks++; if (bus.rx_data !== exp_q[0]) begin errors++; $display("FAIL single_data: got %h expected %h", bus.rx_data, exp_q[0]); end
        checks++; if (fe_seen !== exp_fe) begin errors++; $display("FAIL single_frame_err: got %0d expected %0d", fe_seen, exp_fe); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", rx_busy); end
        pop_one(d);
        void'(exp_q.pop_front());
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after_pop: got %b expected 0", bus.rx_valid); end
        checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL single_count_after_pop: got %0d expected 0", rx_count); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [5];
        logic [7:0] d;
        logic [7:0] e;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'hA5; bytes[3] = 8'h5A; bytes[4] = 8'h0F;
        clk_div = 16'd347;
        for (int i = 0; i < 5; i++) begin
            send_byte(bytes[i], 1'b1, 347);
            model_frame(bytes[i], 1'b1);
        end
        wait_clk(8);
        checks++; if (ov_seen !== exp_ov) begin errors++; $display("FAIL b2b_overrun_cycles: got %0d expected %0d", ov_seen, exp_ov); end
        checks++; if (rx_count !== 3'(exp_q.size())) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", rx_count, exp_q.size()); end
        for (int i = 0; i < DEPTH; i++) begin
            e = exp_q.pop_front();
            checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== e) begin errors++; $display("FAIL b2b_pop%0d: got valid=%b data=%h expected valid=1 data=%h", i, bus.rx_valid, bus.rx_data, e); end
            pop_one(d);
        end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", bus.rx_valid); end
    endtask

    task automatic test_framing;
        logic [7:0] d;
        clk_div = 16'd50;
        send_byte(8'h55, 1'b0, 50);
        model_frame(8'h55, 1'b0);
        wait_clk(500);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL frame_busy_low: got %b expected 1", rx_busy); end
        wait_clk(500);
        checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL frame_no_push: got %0d expected 0", rx_count); end
        checks++; if (fe_seen !== exp_fe) begin errors++; $display("FAIL frame_err_pulses: got %0d expected %0d", fe_seen, exp_fe); end
        ser_rx = 1'b1;
        wait_clk(100);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL frame_idle_after_release: got %b expected 0", rx_busy); end
        send_byte(8'h3D, 1'b1, 50);
        model_frame(8'h3D, 1'b1);
        wait_clk(8);
        checks++; if (rx_count !== 3'(exp_q.size()) || bus.rx_data !== exp_q[0]) begin errors++; $display("FAIL frame_next_byte: got count=%0d data=%h expected count=%0d data=%h", rx_count, bus.rx_data, exp_q.size(), exp_q[0]); end
        checks++; if (fe_seen !== exp_fe) begin errors++; $display("FAIL frame_err_total: got %0d expected %0d", fe_seen, exp_fe); end
        pop_one(d);
        void'(exp_q.pop_front());
    endtask

    task automatic test_glitch;
        logic [7:0] d;
        clk_div = 16'd32;
        ser_rx = 1'b0;
        wait_clk(8);
        ser_rx = 1'b1;
        wait_clk(40);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b expected 0", rx_busy); end
        checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL glitch_no_push: got %0d expected 0", rx_count); end
        checks++; if (fe_seen !== exp_fe) begin errors++; $display("FAIL glitch_no_err: got %0d expected %0d", fe_seen, exp_fe); end
        send_byte(8'hC3, 1'b1, 32);
        model_frame(8'hC3, 1'b1);
        wait_clk(8);
        checks++; if (rx_count !== 3'(exp_q.size()) || bus.rx_data !== exp_q[0]) begin errors++; $display("FAIL glitch_next_byte: got count=%0d data=%h expected count=%0d data=%h", rx_count, bus.rx_data, exp_q.size(), exp_q[0]); end
        pop_one(d);
        void'(exp_q.pop_front());
    endtask

    task automatic test_clamp_enable;
        logic [7:0] d;
        logic [7:0] partial;
        clk_div = 16'd2;
        send_byte(8'h81, 1'b1, eff_div(2));
        model_frame(8'h81, 1'b1);
        wait_clk(8);
        checks++; if (rx_count !== 3'(exp_q.size()) || bus.rx_data !== exp_q[0]) begin errors++; $display("FAIL clamp_byte: got count=%0d data=%h expected count=%0d data=%h", rx_count, bus.rx_data, exp_q.size(), exp_q[0]); end
        pop_one(d);
        void'(exp_q.pop_front());

        clk_div = 16'd16;
        partial = 8'h5A;
        ser_rx = 1'b0;
        wait_clk(16);
        for (int i = 0; i < 3; i++) begin
            ser_rx = partial[i];
            wait_clk(16);
        end
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL enable_busy_mid: got %b expected 1", rx_busy); end
        rx_en = 1'b0;
        wait_clk(1);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL enable_drop_idle: got %b expected 0", rx_busy); end
        ser_rx = 1'b1;
        wait_clk(200);
        checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL enable_no_push: got %0d expected 0", rx_count); end
        rx_en = 1'b1;
        wait_clk(4);
        send_byte(8'h7E, 1'b1, 16);
        model_frame(8'h7E, 1'b1);
        wait_clk(8);
        checks++; if (rx_count !== 3'(exp_q.size()) || bus.rx_data !== exp_q[0]) begin errors++; $display("FAIL enable_next_byte: got count=%0d data=%h expected count=%0d data=%h", rx_count, bus.rx_data, exp_q.size(), exp_q[0]); end
        pop_one(d);
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        clk_div = 16'd16;
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1, 16);
            model_frame(b, 1'b1);
        end
        wait_clk(8);
        ser_rx = 1'b0;
        wait_clk(16);
        ser_rx = 1'b1;
        wait_clk(16);
        ser_rx = 1'b0;
        wait_clk(10);
        rst_n = 1'b0;
        ser_rx = 1'b1;
        wait_clk(2);
        checks++; if (bus.rx_valid !== 1'b0 || rx_count !== 3'd0 || bus.rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_fifo: got valid=%b count=%0d data=%h expected 0 0 00", bus.rx_valid, rx_count, bus.rx_data); end
        checks++; if (rx_busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got busy=%b fe=%b ov=%b expected 0 0 0", rx_busy, frame_err, overrun); end
        rst_n = 1'b1;
        exp_q.delete();
        wait_clk(16 * 12);
        checks++; if (rx_count !== 3'd0 || rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_partial: got count=%0d busy=%b expected 0 0", rx_count, rx_busy); end
    endtask

    task automatic test_push_pop_full;
        logic [7:0] b;
        logic [7:0] d;
        logic [7:0] e;
        int ov_base;
        clk_div = 16'd16;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1, 16);
            model_frame(b, 1'b1);
        end
        wait_clk(8);
        checks++; if (rx_count !== 3'(DEPTH)) begin errors++; $display("FAIL pp_full: got %0d expected %0d", rx_count, DEPTH); end
        ov_base = exp_ov;
        // Stop bit is sampled 2 sync cycles + half a bit + 9 bits after the start edge.
        fork
            send_byte(8'h3C, 1'b1, 16);
            begin
                wait_clk(2 + 8 + 9 * 16);
                checks++; if (rx_count !== 3'(DEPTH)) begin errors++; $display("FAIL pp_full_before_edge: got %0d expected %0d", rx_count, DEPTH); end
                bus.rx_ready = 1'b1;
                @(negedge clk);
                bus.rx_ready = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        exp_q.push_back(8'h3C);
        wait_clk(8);
        checks++; if (ov_seen !== ov_base) begin errors++; $display("FAIL pp_no_overrun: got %0d expected %0d", ov_seen, ov_base); end
        checks++; if (rx_count !== 3'(exp_q.size())) begin errors++; $display("FAIL pp_count: got %0d expected %0d", rx_count, exp_q.size()); end
        for (int i = 0; i < DEPTH; i++) begin
            e = exp_q.pop_front();
            checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== e) begin errors++; $display("FAIL pp_pop%0d: got valid=%b data=%h expected valid=1 data=%h", i, bus.rx_valid, bus.rx_data, e); end
            pop_one(d);
        end
    endtask

    task automatic test_random;
        logic [7:0] b;
        logic [7:0] d;
        int cd;
        for (int n = 0; n < 10; n++) begin
            cd = int'($urandom_range(0, 40));
            clk_div = DIV_W'(cd);
            b = 8'($urandom);
            send_byte(b, 1'b1, eff_div(cd));
            model_frame(b, 1'b1);
            wait_clk(8);
            checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== exp_q[0] || rx_count !== 3'(exp_q.size())) begin errors++; $display("FAIL rand%0d_div%0d: got valid=%b data=%h count=%0d expected valid=1 data=%h count=%0d", n, cd, bus.rx_valid, bus.rx_data, rx_count, exp_q[0], exp_q.size()); end
            pop_one(d);
            void'(exp_q.pop_front());
        end
        checks++; if (fe_seen !== exp_fe || ov_seen !== exp_ov) begin errors++; $display("FAIL rand_pulses: got fe=%0d ov=%0d expected fe=%0d ov=%0d", fe_seen, ov_seen, exp_fe, exp_ov); end
    endtask

    initial begin
        bus.rx_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_clamp_enable();
        test_reset_mid();
        test_push_pop_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
